cpu_clock_controller: RTL
=========================

# cpu_clock_controller

Sequences the MIPS core's execution clock from a single board clock. Produces a one-cycle clock-enable `cpu_ce` in three modes: free-running at a programmable divide ratio, single-step from a push button, or stopped after a break request from the core. It sits between the board clock/switch inputs and every core register that advances per instruction. All core state stays on `clk_in`; only the enable is gated.

## Interface
- `DIV_W`, 32: width of divide register and divider counter
- `CNT_W`, 32: width of executed-cycle counter
- `DEFAULT_DIV`, 50_000_000: divide ratio loaded at reset
- `clk_in` input 1: board clock, all logic on rising edge
- `rst_n` input 1: asynchronous, active-low reset; one clock, no other clocks
- `run_sw` input 1: asynchronous level, 1 = free-run requested
- `step_btn` input 1: asynchronous level (pre-debounced), rising edge = one step
- `halt_req` input 1: synchronous to `clk_in`, from core (break/syscall), level
- `div_load` input 1: synchronous strobe, load `div_value`
- `div_value` input DIV_W: new divide ratio
- `cpu_ce` output 1: registered one-cycle enable for core
- `state` output 2: current FSM state encoding
- `halted` output 1: 1 while in BREAK
- `cycle_count` output CNT_W: number of `cpu_ce` pulses issued

## Operation
- Input conditioning:
  - `run_sw` passes through a 2-flop synchronizer to give `run_s`.
  - `step_btn` passes through a 2-flop synchronizer plus an edge flop to give `step_rise`, a one-cycle pulse.
- States: IDLE=0, RUN=1, STEP=2, BREAK=3.
- IDLE:
  - `halt_req`=1 → BREAK (highest priority).
  - Else `run_s`=1 → RUN, with `div_cnt` cleared to 0.
  - Else `step_rise` → STEP.
  - `step_rise` is ignored when `run_s`=1.
- RUN:
  - `div_cnt` increments each cycle.
  - When `div_cnt == div_reg-1`: `div_cnt` ← 0 and `cpu_ce` ← 1 for the next cycle.
  - `halt_req`=1 → BREAK, with no pulse issued that cycle.
  - Else `run_s`=0 → IDLE, with no pulse issued that cycle.
- STEP: lasts exactly one cycle, with `cpu_ce`=1 during it; then IDLE, or BREAK if `halt_req`=1.
- BREAK:
  - `cpu_ce`=0 and `halted`=1.
  - Step edges are ignored.
  - Exits to IDLE only once `run_s`=0 and `halt_req`=0.
- Divide register:
  - `div_load` writes `div_value` in any state and clears `div_cnt`.
  - A value of 0 is stored as 1, giving a pulse every cycle.
- `cycle_count` increments on every cycle with `cpu_ce`=1 and saturates at all-ones.

## Timing
- Reset values: `state`=IDLE, `cpu_ce`=0, `halted`=0, `cycle_count`=0, `div_cnt`=0, `div_reg`=DEFAULT_DIV, synchronizer flops 0.
- Reset asserted mid-pulse drops `cpu_ce` immediately (asynchronously).
- `run_sw` change to state change: 3 `clk_in` edges (2 sync + 1 FSM).
- `step_btn` rise to `cpu_ce` high: 4 edges (2 sync + edge flop + FSM/`cpu_ce` register).
- RUN entered at cycle 0: first `cpu_ce` at cycle `div_reg`, then every `div_reg` cycles. With `div_reg`=1, `cpu_ce` is high every cycle from cycle 1.
- `cpu_ce` is never high for more than one consecutive cycle except in RUN with `div_reg`=1.
- `div_load` in the same cycle as a terminal count:
  - Load wins: `div_cnt` ← 0 and no pulse.
  - The new period applies from the next cycle.
- `halt_req` in the cycle a pulse is being registered: halt wins, so the pulse is suppressed.

## Structure
- Package `cpu_clk_pkg` holds:
  - the state enum and encodings (IDLE/RUN/STEP/BREAK);
  - the `DEFAULT_DIV` constant;
  - the synchronizer depth constant (2).
- Sub-module `sync_edge`: parameterless 2-flop synchronizer with registered rising-edge output, reset by `rst_n`. Instantiated for `step_btn`; its level output also serves `run_sw`.
- Top level holds the FSM, divider counter, divide register and cycle counter.

## Test plan
- Reset with `run_sw`=0: all outputs at their reset values. Raise `run_sw`, load `div_value`=4 → first `cpu_ce` 4 cycles after RUN entry, then period 4. After 10 pulses, `cycle_count`=10.
- In IDLE, three `step_btn` rises spaced 10 cycles apart → exactly three single-cycle `cpu_ce` pulses, each 4 edges after its rise; `cycle_count`=3.
- RUN with `div_reg`=4, assert `halt_req` on the terminal-count cycle → no pulse, `state`=BREAK, `halted`=1. Step edges are ignored. Drop `run_sw` and `halt_req` → IDLE.
- `div_load` with `div_value`=0 during RUN → `cpu_ce` high every cycle after the load. `div_load`=3 mid-count → counter restarts, next pulse 3 cycles later.
- Preload `cycle_count` near saturation (CNT_W=4 build), run 20 pulses → holds at 15.
- Assert `rst_n`=0 asynchronously while `cpu_ce`=1 in RUN → `cpu_ce` and `state` clear without waiting for a clock edge.

Source files
------------

// File: rtl/cpu_clk_pkg.sv
// Shared types and constants for the CPU clock-enable sequencer.
// State encodings are visible on the controller's state output.
package cpu_clk_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StStep  = 2'd2,
        StBreak = 2'd3
    } clk_state_e;

    localparam int unsigned DefaultDiv = 32'd50_000_000;
    localparam int unsigned SyncDepth  = 2;

endpackage

// File: rtl/cpu_clock_controller_sync_edge.sv
// Multi-flop synchronizer for an asynchronous level, plus a registered
// one-cycle pulse on each rising edge of the synchronized level.
module sync_edge
    import cpu_clk_pkg::*;
(
    input  logic clk_in,
    input  logic rst_n,
    input  logic d_i,
    output logic level_o,
    output logic rise_o
);

    logic [SyncDepth-1:0] sync_q;
    logic                 prev_q;
    logic                 rise_q;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SyncDepth-2:0], d_i};
            prev_q <= sync_q[SyncDepth-1];
            rise_q <= sync_q[SyncDepth-1] & ~prev_q;
        end
    end

    assign level_o = sync_q[SyncDepth-1];
    assign rise_o  = rise_q;

endmodule

// File: rtl/cpu_clock_controller.sv
// Generates the core's one-cycle clock enable: free-run at a programmable
// divide ratio, single-step from a button, or held stopped on a break request.
module cpu_clock_controller
    import cpu_clk_pkg::*;
#(
    parameter int unsigned DIV_W       = 32,
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned DEFAULT_DIV = DefaultDiv
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             run_sw,
    input  logic             step_btn,
    input  logic             halt_req,
    input  logic             div_load,
    input  logic [DIV_W-1:0] div_value,
    output logic             cpu_ce,
    output logic [1:0]       state,
    output logic             halted,
    output logic [CNT_W-1:0] cycle_count
);

    logic run_s;
    logic run_rise;
    logic step_level;
    logic step_rise;
    logic unused_sync;

    sync_edge u_run_sync (
        .clk_in  (clk_in),
        .rst_n   (rst_n),
        .d_i     (run_sw),
        .level_o (run_s),
        .rise_o  (run_rise)
    );

    sync_edge u_step_sync (
        .clk_in  (clk_in),
        .rst_n   (rst_n),
        .d_i     (step_btn),
        .level_o (step_level),
        .rise_o  (step_rise)
    );

    assign unused_sync = run_rise ^ step_level;

    clk_state_e       state_q, state_d;
    logic             cpu_ce_q, cpu_ce_d;
    logic             halted_q, halted_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [DIV_W-1:0] div_reg_q, div_reg_d;
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic             div_term;

    assign div_term = (div_cnt_q == (div_reg_q - DIV_W'(1)));

    always_comb begin
        state_d   = state_q;
        cpu_ce_d  = 1'b0;
        div_cnt_d = div_cnt_q;
        div_reg_d = div_reg_q;

        unique case (state_q)
            StIdle: begin
                if (halt_req) begin
                    state_d = StBreak;
                end else if (run_s) begin
                    state_d   = StRun;
                    div_cnt_d = '0;
                end else if (step_rise) begin
                    state_d  = StStep;
                    cpu_ce_d = 1'b1;
                end
            end
            StRun: begin
                if (halt_req) begin
                    state_d = StBreak;
                end else if (!run_s) begin
                    state_d = StIdle;
                end else if (div_term) begin
                    div_cnt_d = '0;
                    cpu_ce_d  = 1'b1;
                end else begin
                    div_cnt_d = div_cnt_q + DIV_W'(1);
                end
            end
            StStep: begin
                state_d = halt_req ? StBreak : StIdle;
            end
            StBreak: begin
                if (!run_s && !halt_req) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // A load restarts the period; in RUN it also swallows a coincident terminal pulse.
        if (div_load) begin
            div_reg_d = (div_value == '0) ? DIV_W'(1) : div_value;
            div_cnt_d = '0;
            if (state_q == StRun) begin
                cpu_ce_d = 1'b0;
            end
        end

        halted_d = (state_d == StBreak);
    end

    always_comb begin
        cycle_cnt_d = cycle_cnt_q;
        if (cpu_ce_q && (cycle_cnt_q != '1)) begin
            cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cpu_ce_q    <= 1'b0;
            halted_q    <= 1'b0;
            div_cnt_q   <= '0;
            div_reg_q   <= DIV_W'(DEFAULT_DIV);
            cycle_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cpu_ce_q    <= cpu_ce_d;
            halted_q    <= halted_d;
            div_cnt_q   <= div_cnt_d;
            div_reg_q   <= div_reg_d;
            cycle_cnt_q <= cycle_cnt_d;
        end
    end

    assign cpu_ce      = cpu_ce_q;
    assign state       = state_q;
    assign halted      = halted_q;
    assign cycle_count = cycle_cnt_q;

endmodule
